line_buffer_ctrl: RTL and testbench

LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

---
 rtl/line_buffer_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// Line-buffer controller for a census-transform window.
// Tracks the column/row of each accepted pixel, drives the shift enable for
// the line-buffer delay FIFOs and window registers, and reports the
// window-centre coordinate whenever a full WIN x WIN window is available.
// Optional feature macro: LINE_BUFFER_CTRL_SOF_ERR_EN adds a sticky
// premature start-of-frame error flag; without it, sof_err is tied to 0.
module line_buffer_ctrl #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned WIN    = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_sof,
  output logic                      shift_en,
  output logic                      win_valid,
  output logic [$clog2(WIDTH)-1:0]  win_col,
  output logic [$clog2(HEIGHT)-1:0] win_row,
  output logic                      frame_done,
  output logic                      sof_err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);

  // Counter limits and window thresholds at counter width.
  localparam logic [CW-1:0] COL_LAST      = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(WIN - 2);
  localparam logic [CW-1:0] COL_WIN_MIN   = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_WIN_MIN   = RW'(WIN - 1);
  localparam logic [CW-1:0] COL_HALF      = CW'((WIN - 1) / 2);
  localparam logic [RW-1:0] ROW_HALF      = RW'((WIN - 1) / 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // State and position of the next pixel to be accepted.
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_col;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] r_row;
  logic [RW-1:0] w_row_nxt;

  // Registered outputs and their next values.
  logic          r_shift_en;
  logic          w_shift_en_nxt;
  logic          r_win_valid;
  logic          w_win_valid_nxt;
  logic [CW-1:0] r_win_col;
  logic [CW-1:0] w_win_col_nxt;
  logic [RW-1:0] r_win_row;
  logic [RW-1:0] w_win_row_nxt;
  logic          r_frame_done;
  logic          w_frame_done_nxt;

  // Per-cycle decode of the incoming pixel.
  logic w_accept;
  logic w_last_col;
  logic w_last_pix;
  logic w_restart;
  logic w_win_hit;

  // A pixel is taken when a frame is open, or when it opens one.
  assign w_accept   = in_valid && ((r_state != IDLE) || in_sof);
  assign w_last_col = (r_col == COL_LAST);
  assign w_last_pix = w_last_col && (r_row == ROW_LAST);

  // The pixel becomes (0,0) of a new frame: either the frame opens from IDLE,
  // or an in-frame SOF arrives. SOF on the final pixel closes the frame
  // normally instead.
  assign w_restart  = (r_state == IDLE) || (in_sof && !w_last_pix);

  // Full window available once both coordinates reach WIN-1.
  assign w_win_hit  = (r_col >= COL_WIN_MIN) && (r_row >= ROW_WIN_MIN);

  // State and position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Next-state, counter advance and next output values.
  always_comb begin
    w_state_nxt      = r_state;
    w_col_nxt        = r_col;
    w_row_nxt        = r_row;
    w_shift_en_nxt   = 1'b0;
    w_win_valid_nxt  = 1'b0;
    w_win_col_nxt    = r_win_col;
    w_win_row_nxt    = r_win_row;
    w_frame_done_nxt = 1'b0;

    if (w_accept) begin
      w_shift_en_nxt = 1'b1;
      if (w_restart) begin
        // Restarted pixel sits at column 0, so it never completes a window.
        w_state_nxt = FILL;
        w_col_nxt   = CW'(1);
        w_row_nxt   = '0;
      end else begin
        if (w_win_hit) begin
          w_win_valid_nxt = 1'b1;
          w_win_col_nxt   = r_col - COL_HALF;
          w_win_row_nxt   = r_row - ROW_HALF;
        end

        if (w_last_col) begin
          w_col_nxt = '0;
          if (w_last_pix) begin
            w_row_nxt        = '0;
            w_state_nxt      = IDLE;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_row_nxt = r_row + RW'(1);
          end
        end else begin
          w_col_nxt = r_col + CW'(1);
        end

        case (r_state)
          FILL: begin
            // Last pre-window row completes: window rows now available.
            if (w_last_col && (r_row == ROW_FILL_LAST)) begin
              w_state_nxt = STREAM;
            end
          end
          STREAM: begin
            // Frame end is handled above with the counters.
          end
          default: begin
            w_state_nxt = IDLE;
          end
        endcase
      end
    end
  end

  // Output registers; each reflects the pixel accepted one cycle earlier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift_en   <= 1'b0;
      r_win_valid  <= 1'b0;
      r_win_col    <= '0;
      r_win_row    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_shift_en   <= w_shift_en_nxt;
      r_win_valid  <= w_win_valid_nxt;
      r_win_col    <= w_win_col_nxt;
      r_win_row    <= w_win_row_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign shift_en   = r_shift_en;
  assign win_valid  = r_win_valid;
  assign win_col    = r_win_col;
  assign win_row    = r_win_row;
  assign frame_done = r_frame_done;

`ifdef LINE_BUFFER_CTRL_SOF_ERR_EN
  logic r_sof_err;
  logic w_premature;

  // In-frame SOF that is not on the final pixel.
  assign w_premature = in_valid && in_sof && (r_state != IDLE) && !w_last_pix;

  // Sticky premature-SOF flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sof_err <= 1'b0;
    end else if (w_premature) begin
      r_sof_err <= 1'b1;
    end
  end

  assign sof_err = r_sof_err;
`else
  assign sof_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl at WIDTH=8, HEIGHT=6, WIN=3.
module tb_line_buffer_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WN = 3;
  localparam int NPIX = W * H;

`ifdef LINE_BUFFER_CTRL_SOF_ERR_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic       shift_en;
  logic       win_valid;
  logic [2:0] win_col;
  logic [2:0] win_row;
  logic       frame_done;
  logic       sof_err;

  line_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .WIN(WN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .shift_en   (shift_en),
    .win_valid  (win_valid),
    .win_col    (win_col),
    .win_row    (win_row),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_shift;
  int n_wv;
  int exp_col;
  int exp_row;
  bit exp_se;
  int fd_q[$];

  typedef struct {
    bit v;
    bit s;
    bit sh;
    bit wv;
    bit fd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 ns after the edge.
  task automatic cycle(input bit v, input bit s);
    in_valid = v;
    in_sof   = s;
    @(posedge clk);
    #1;
    cyc++;
    if (shift_en)   n_shift++;
    if (win_valid)  n_wv++;
    if (frame_done) fd_q.push_back(cyc);
  endtask

  task automatic check_outs(input string tag, input bit sh, input bit wv, input bit fd);
    chk($sformatf("%s shift_en", tag),   int'(shift_en),   int'(sh));
    chk($sformatf("%s win_valid", tag),  int'(win_valid),  int'(wv));
    chk($sformatf("%s win_col", tag),    int'(win_col),    exp_col);
    chk($sformatf("%s win_row", tag),    int'(win_row),    exp_row);
    chk($sformatf("%s frame_done", tag), int'(frame_done), int'(fd));
    chk($sformatf("%s sof_err", tag),    int'(sof_err),    int'(exp_se));
  endtask

  // Feed frame pixels first..last (raster index); optional 2-cycle gaps.
  task automatic run_pixels(input int first, input int last, input bit gap,
                            input bit sof_first, input bit sof_last);
    for (int i = first; i <= last; i++) begin
      int c;
      int r;
      bit wv;
      c = i % W;
      r = i / W;
      cycle(1'b1, (sof_first && i == first) || (sof_last && i == last));
      wv = (c >= WN - 1) && (r >= WN - 1);
      if (wv) begin
        exp_col = c - (WN - 1) / 2;
        exp_row = r - (WN - 1) / 2;
      end
      check_outs($sformatf("px%0d", i), 1'b1, wv, i == NPIX - 1);
      if (gap) begin
        for (int g = 0; g < 2; g++) begin
          cycle(1'b0, 1'b0);
          check_outs($sformatf("gap%0d", i), 1'b0, 1'b0, 1'b0);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    exp_col  = 0;
    exp_row  = 0;
    exp_se   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    //           v     s     sh    wv    fd
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // SOF without valid in IDLE
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // valid without SOF dropped
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // frame opens, pixel (0,0)
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // stall
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // (1,0)
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // SOF without valid mid-frame
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // (2,0): row 0, no window
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // (3,0)

    do_reset();

    foreach (tbl[k]) begin
      cycle(tbl[k].v, tbl[k].s);
      check_outs($sformatf("vec%0d", k), tbl[k].sh, tbl[k].wv, tbl[k].fd);
    end

    // Asynchronous reset while shift_en is high.
    rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0);
      check_outs("post_rst_nosof", 1'b0, 1'b0, 1'b0);
    end

    // Continuous frame.
    n_shift = 0;
    n_wv    = 0;
    run_pixels(0, NPIX - 1, 1'b0, 1'b1, 1'b0);
    chk("cont shift count", n_shift, NPIX);
    chk("cont win count", n_wv, 24);
    chk("cont last win_col", exp_col, 6);
    cycle(1'b0, 1'b0);
    check_outs("cont idle", 1'b0, 1'b0, 1'b0);

    // Frame with in_valid pattern 1,0,0,1,0,0,...
    n_shift = 0;
    n_wv    = 0;
    run_pixels(0, NPIX - 1, 1'b1, 1'b1, 1'b0);
    chk("gap shift count", n_shift, NPIX);
    chk("gap win count", n_wv, 24);

    // Premature SOF at index 29; frame restarts there.
    fd_q.delete();
    run_pixels(0, 28, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    exp_se = SOF_EN;
    check_outs("premature", 1'b1, 1'b0, 1'b0);
    chk("premature no fd", fd_q.size(), 0);
    run_pixels(1, NPIX - 1, 1'b0, 1'b0, 1'b0);
    chk("restart fd count", fd_q.size(), 1);
    do_reset();

    // Back-to-back frames.
    fd_q.delete();
    run_pixels(0, NPIX - 1, 1'b0, 1'b1, 1'b0);
    run_pixels(0, NPIX - 1, 1'b0, 1'b1, 1'b0);
    chk("b2b fd count", fd_q.size(), 2);
    if (fd_q.size() == 2) chk("b2b fd spacing", fd_q[1] - fd_q[0], NPIX);

    // SOF on the final pixel closes the frame; the next pixel needs a new SOF.
    run_pixels(0, NPIX - 1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    check_outs("after_last_sof", 1'b0, 1'b0, 1'b0);
    run_pixels(0, NPIX - 1, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
